rf_dump_reader: RTL and testbench

Debug read-out engine that walks the CPU register file through one read port and streams each register value out over a valid/ready interface, e.g. to a UART or debug FIFO.
- Sits beside the register file and drives its read address; read data returns combinationally in the same cycle.
- Asserts a CPU hold request for the whole dump so the streamed snapshot is coherent.
- Register 0 reads as zero by register-file convention; no special handling here.

---
 rtl/rf_dump_reader_pkg.sv | 19 +
 rtl/rf_dump_reader_if.sv | 33 +++
 rtl/rf_dump_reader.sv | 133 +++++++++++++
 tb/tb_rf_dump_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: default widths and
// the FSM state encoding.
package rf_dump_reader_pkg;

    localparam int unsigned RF_AW = 5;
    localparam int unsigned RF_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    // Next register index; plain AW-bit increment, callers guarantee no wrap.
    function automatic logic [RF_AW-1:0] next_index(input logic [RF_AW-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rf_dump_reader_if.sv
// Register-file read port plus valid/ready output stream of the dump reader.
// master = dump reader side, slave = register file / downstream consumer side.
interface rf_dump_reader_if #(
    parameter int unsigned AW = rf_dump_reader_pkg::RF_AW,
    parameter int unsigned DW = rf_dump_reader_pkg::RF_DW
);

    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index
    );

endinterface

// File: rtl/rf_dump_reader.sv
// Debug read-out engine: walks register indices FIRST_REG..LAST_REG through
// the register-file read port and streams each value out over valid/ready,
// holding the CPU for the whole dump so the snapshot is coherent.
module rf_dump_reader
    import rf_dump_reader_pkg::*;
#(
    parameter int unsigned AW        = RF_AW,
    parameter int unsigned DW        = RF_DW,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    rf_dump_reader_if.master  bus,
    output logic              busy,
    output logic              hold_cpu,
    output logic              done
);

    localparam logic [AW-1:0] FIRST_A = AW'(FIRST_REG);
    localparam logic [AW-1:0] LAST_A  = AW'(LAST_REG);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW-1:0] r_addr;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [AW-1:0] r_index;
    logic          r_done;

    logic [AW-1:0] w_addr_nxt;
    logic          w_valid_nxt;
    logic [DW-1:0] w_data_nxt;
    logic [AW-1:0] w_index_nxt;
    logic          w_done_nxt;

    logic          w_handshake;
    logic          w_at_last;

    assign w_handshake = r_valid & bus.out_ready;
    assign w_at_last   = (r_addr == LAST_A);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values; abort outranks a same-cycle handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_index_nxt = r_index;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_addr_nxt  = FIRST_A;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    w_addr_nxt  = FIRST_A;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_data_nxt  = bus.rd_data;
                    w_index_nxt = r_addr;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    w_addr_nxt  = FIRST_A;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end else if (w_handshake) begin
                    w_valid_nxt = 1'b0;
                    if (w_at_last) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_addr_nxt  = next_index(r_addr);
                        w_state_nxt = LOAD;
                    end
                end
            end
            default: begin
                w_addr_nxt  = FIRST_A;
                w_valid_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers: read address, captured word, and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= FIRST_A;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_done  <= 1'b0;
        end else begin
            r_addr  <= w_addr_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_index <= w_index_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.rd_addr   = r_addr;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_index = r_index;

    assign busy     = (r_state != IDLE);
    assign hold_cpu = busy;
    assign done     = r_done;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: full dump, backpressure, ignored start,
// abort, async reset mid-dump, and a single-register configuration.
module tb_rf_dump_reader;

    logic clk;
    logic reset;
    logic start0, abort0, busy0, hold0, done0;
    logic start1, abort1, busy1, hold1, done1;

    logic [31:0] regs [0:31];

    int n_checks;
    int n_pass;

    rf_dump_reader_if #(.AW(5), .DW(32)) if0 ();
    rf_dump_reader_if #(.AW(5), .DW(32)) if1 ();

    assign if0.rd_data = regs[if0.rd_addr];
    assign if1.rd_data = regs[if1.rd_addr];

    rf_dump_reader #(.AW(5), .DW(32), .FIRST_REG(0), .LAST_REG(31)) u0 (
        .clk      (clk),
        .reset    (reset),
        .start    (start0),
        .abort    (abort0),
        .bus      (if0.master),
        .busy     (busy0),
        .hold_cpu (hold0),
        .done     (done0)
    );

    rf_dump_reader #(.AW(5), .DW(32), .FIRST_REG(5), .LAST_REG(5)) u1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start1),
        .abort    (abort1),
        .bus      (if1.master),
        .busy     (busy1),
        .hold_cpu (hold1),
        .done     (done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] val(input int i);
        logic [31:0] a;
        a = 32'(i);
        return a * 32'h11111111;
    endfunction

    task automatic test_reset();
        n_checks++; if (if0.out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", if0.out_valid); else n_pass++;
        n_checks++; if (if0.out_data !== 32'h0) $display("FAIL reset_data got %0h exp 0", if0.out_data); else n_pass++;
        n_checks++; if (if0.out_index !== 5'd0) $display("FAIL reset_index got %0d exp 0", if0.out_index); else n_pass++;
        n_checks++; if (if0.rd_addr !== 5'd0) $display("FAIL reset_rd_addr got %0d exp 0", if0.rd_addr); else n_pass++;
        n_checks++; if (busy0 !== 1'b0 || hold0 !== 1'b0) $display("FAIL reset_busy got %0b/%0b exp 0/0", busy0, hold0); else n_pass++;
        n_checks++; if (done0 !== 1'b0) $display("FAIL reset_done got %0b exp 0", done0); else n_pass++;
        n_checks++; if (if1.rd_addr !== 5'd5) $display("FAIL reset_rd_addr_single got %0d exp 5", if1.rd_addr); else n_pass++;
    endtask

    task automatic test_full_dump();
        int k, cyc, done_cyc, first_cyc;
        if0.out_ready = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1;
        n_checks++; if (busy0 !== 1'b1 || if0.out_valid !== 1'b0) $display("FAIL full_load busy/valid got %0b/%0b exp 1/0", busy0, if0.out_valid); else n_pass++;
        k = 0; done_cyc = -1; first_cyc = -1;
        while (done_cyc < 0 && cyc < 200) begin
            if (if0.out_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
            n_checks++;
            if (hold0 !== (cyc < 65) || busy0 !== (cyc < 65)) $display("FAIL full_hold cyc %0d got %0b/%0b exp %0b", cyc, hold0, busy0, (cyc < 65));
            else n_pass++;
            if (if0.out_valid === 1'b1) begin
                n_checks++;
                if (if0.out_index !== 5'(k) || if0.out_data !== val(k))
                    $display("FAIL full_word got idx %0d data %0h exp idx %0d data %0h", if0.out_index, if0.out_data, k, val(k));
                else n_pass++;
                k++;
            end
            if (done0 === 1'b1) done_cyc = cyc;
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (first_cyc != 2) $display("FAIL full_first_valid got cyc %0d exp 2", first_cyc); else n_pass++;
        n_checks++; if (done_cyc != 65) $display("FAIL full_done_time got cyc %0d exp 65", done_cyc); else n_pass++;
        n_checks++; if (k != 32) $display("FAIL full_word_count got %0d exp 32", k); else n_pass++;
        n_checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) $display("FAIL full_done_pulse got done %0b busy %0b exp 0/0", done0, busy0); else n_pass++;
    endtask

    task automatic test_backpressure();
        int k, cyc, done_cyc, stall;
        if0.out_ready = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1; k = 0; done_cyc = -1; stall = 0;
        while (done_cyc < 0 && cyc < 200) begin
            if (stall > 0 && stall < 5 && if0.out_valid !== 1'b1) begin
                n_checks++;
                $display("FAIL bp_valid_held got %0b exp 1", if0.out_valid);
            end
            if (if0.out_valid === 1'b1) begin
                n_checks++;
                if (if0.out_index !== 5'(k) || if0.out_data !== val(k))
                    $display("FAIL bp_word got idx %0d data %0h exp idx %0d data %0h", if0.out_index, if0.out_data, k, val(k));
                else n_pass++;
                if (k == 3 && stall < 5) begin
                    if0.out_ready = 1'b0;
                    stall++;
                end else begin
                    if0.out_ready = 1'b1;
                    k++;
                end
            end
            if (done0 === 1'b1) done_cyc = cyc;
            @(negedge clk);
            cyc++;
        end
        if0.out_ready = 1'b1;
        n_checks++; if (stall != 5) $display("FAIL bp_stall_cycles got %0d exp 5", stall); else n_pass++;
        n_checks++; if (k != 32) $display("FAIL bp_word_count got %0d exp 32", k); else n_pass++;
        n_checks++; if (done_cyc != 70) $display("FAIL bp_done_time got cyc %0d exp 70", done_cyc); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int k, cyc, done_cyc, n_done;
        if0.out_ready = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1; k = 0; done_cyc = -1; n_done = 0;
        while (cyc < 75) begin
            start0 = 1'b0;
            if (if0.out_valid === 1'b1) begin
                n_checks++;
                if (if0.out_index !== 5'(k) || if0.out_data !== val(k))
                    $display("FAIL restart_word got idx %0d data %0h exp idx %0d data %0h", if0.out_index, if0.out_data, k, val(k));
                else n_pass++;
                if (k == 10) start0 = 1'b1;
                k++;
            end
            if (done0 === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        start0 = 1'b0;
        n_checks++; if (k != 32) $display("FAIL restart_word_count got %0d exp 32", k); else n_pass++;
        n_checks++; if (n_done != 1) $display("FAIL restart_done_count got %0d exp 1", n_done); else n_pass++;
        n_checks++; if (done_cyc != 65) $display("FAIL restart_done_time got cyc %0d exp 65", done_cyc); else n_pass++;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL restart_idle_after got busy %0b exp 0", busy0); else n_pass++;
    endtask

    task automatic test_abort();
        int cyc;
        bit found;
        if0.out_ready = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        found = 1'b0;
        for (cyc = 0; cyc < 100 && !found; cyc++) begin
            if (if0.out_valid === 1'b1 && if0.out_index === 5'd7) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (!found) $display("FAIL abort_reach_word7 got timeout exp index 7"); else n_pass++;
        n_checks++; if (if0.out_data !== val(7)) $display("FAIL abort_word7_data got %0h exp %0h", if0.out_data, val(7)); else n_pass++;
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        n_checks++; if (if0.out_valid !== 1'b0) $display("FAIL abort_valid got %0b exp 0", if0.out_valid); else n_pass++;
        n_checks++; if (busy0 !== 1'b0 || hold0 !== 1'b0) $display("FAIL abort_busy got %0b/%0b exp 0/0", busy0, hold0); else n_pass++;
        n_checks++; if (if0.rd_addr !== 5'd0) $display("FAIL abort_rd_addr got %0d exp 0", if0.rd_addr); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (done0 !== 1'b0) $display("FAIL abort_no_done got %0b exp 0", done0); else n_pass++;
            @(negedge clk);
        end
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (if0.out_valid !== 1'b1 || if0.out_index !== 5'd0 || if0.out_data !== 32'h0)
            $display("FAIL abort_restart got valid %0b idx %0d data %0h exp 1/0/0", if0.out_valid, if0.out_index, if0.out_data);
        else n_pass++;
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL abort_second got busy %0b exp 0", busy0); else n_pass++;
    endtask

    task automatic test_abort_idle();
        start0 = 1'b1;
        abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort0 = 1'b0;
        n_checks++; if (busy0 !== 1'b0 || if0.out_valid !== 1'b0) $display("FAIL idle_abort_start got busy %0b valid %0b exp 0/0", busy0, if0.out_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy0 !== 1'b0) $display("FAIL idle_abort_stay got busy %0b exp 0", busy0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found;
        if0.out_ready = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            if (if0.out_valid === 1'b1 && if0.out_index === 5'd5) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (!found) $display("FAIL rstmid_reach_word5 got timeout exp index 5"); else n_pass++;
        if0.out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (if0.out_valid !== 1'b0) $display("FAIL rstmid_valid got %0b exp 0", if0.out_valid); else n_pass++;
        n_checks++; if (busy0 !== 1'b0 || hold0 !== 1'b0) $display("FAIL rstmid_busy got %0b/%0b exp 0/0", busy0, hold0); else n_pass++;
        n_checks++; if (done0 !== 1'b0) $display("FAIL rstmid_done got %0b exp 0", done0); else n_pass++;
        n_checks++; if (if0.out_index !== 5'd0 || if0.rd_addr !== 5'd0) $display("FAIL rstmid_index got %0d/%0d exp 0/0", if0.out_index, if0.rd_addr); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_full_dump();
    endtask

    task automatic test_single();
        if1.out_ready = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n_checks++; if (busy1 !== 1'b1 || if1.out_valid !== 1'b0) $display("FAIL single_load got busy %0b valid %0b exp 1/0", busy1, if1.out_valid); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (if1.out_valid !== 1'b1 || if1.out_index !== 5'd5 || if1.out_data !== val(5))
            $display("FAIL single_word got valid %0b idx %0d data %0h exp 1/5/%0h", if1.out_valid, if1.out_index, if1.out_data, val(5));
        else n_pass++;
        @(negedge clk);
        n_checks++; if (done1 !== 1'b1 || busy1 !== 1'b0 || if1.out_valid !== 1'b0) $display("FAIL single_done got done %0b busy %0b valid %0b exp 1/0/0", done1, busy1, if1.out_valid); else n_pass++;
        n_checks++; if (if1.rd_addr !== 5'd5) $display("FAIL single_no_wrap got rd_addr %0d exp 5", if1.rd_addr); else n_pass++;
        @(negedge clk);
        n_checks++; if (done1 !== 1'b0) $display("FAIL single_done_pulse got %0b exp 0", done1); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 32; i++) regs[i] = val(i);
        reset  = 1'b0;
        start0 = 1'b0; abort0 = 1'b0;
        start1 = 1'b0; abort1 = 1'b0;
        if0.out_ready = 1'b0;
        if1.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_full_dump();
        test_backpressure();
        test_start_ignored();
        test_abort();
        test_abort_idle();
        test_reset_mid();
        test_single();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
